delta_distributor: RTL and testbench

Backward-pass counterpart of the neuron's 33-input forward summer. The summer reduces N_IN weighted inputs plus a bias lane into one `real` sum. This block takes a single error term (delta) for the neuron and fans it back out across the same N_IN+1 lanes. It streams one per-lane back-propagated error, `delta * w[i]`, per handshake to the previous layer's error accumulator. It sits between the neuron's activation-derivative stage and the upstream layer's error collection.

---
 rtl/neuron_pkg.sv | 17 +
 rtl/delta_distributor.sv | 138 +++++++++++++
 tb/tb_delta_distributor.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared neuron definitions: default lane count, stream FSM states and the
// lane-index type used by the forward summer and the backward distributor.
package neuron_pkg;

    // Default number of weighted input lanes; the bias lane sits at index N_IN.
    localparam int N_IN_DEFAULT = 32;

    // Two-state stream controller.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Lane index wide enough to address lanes 0..N_IN_DEFAULT inclusive.
    typedef logic [$clog2(N_IN_DEFAULT + 1)-1:0] lane_idx_t;

endpackage

// File: rtl/delta_distributor.sv
// delta_distributor: latches one neuron error term plus its lane weights,
// then streams delta*w[i] for lanes 0..N_IN (bias last) over a valid/ready
// handshake. Optional gradient output enabled by macro DELTA_DIST_GRAD_EN.
module delta_distributor
    import neuron_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int IDX_W = $clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    output logic             d_ready,
    input  real              d_delta,
    input  real              d_weights [N_IN:0],
`ifdef DELTA_DIST_GRAD_EN
    input  real              d_acts [N_IN-1:0],
    output real              e_grad,
`endif
    output logic             e_valid,
    input  logic             e_ready,
    output logic [IDX_W-1:0] e_index,
    output real              e_err,
    output logic             e_last,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    real              delta_q, delta_d;
    real              w_q [N_IN:0];
    real              w_d [N_IN:0];
`ifdef DELTA_DIST_GRAD_EN
    // One extra slot holds the bias activation (1.0) so the same lane index
    // selects both the weight and the activation.
    real              act_q [N_IN:0];
    real              act_d [N_IN:0];
`endif

    logic             lane_hs_s;

    assign lane_hs_s = (state_q == STREAM) && e_ready;

    // Next-state logic: snapshot inputs on accept, walk the lane counter on each handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        delta_d = delta_q;
        w_d     = w_q;
`ifdef DELTA_DIST_GRAD_EN
        act_d   = act_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_valid) begin
                    delta_d = d_delta;
                    w_d     = d_weights;
`ifdef DELTA_DIST_GRAD_EN
                    for (int i = 0; i < N_IN; i++) begin
                        act_d[i] = d_acts[i];
                    end
                    act_d[N_IN] = 1.0;
`endif
                    idx_d   = {IDX_W{1'b0}};
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (lane_hs_s) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                idx_d   = {IDX_W{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // State, lane counter and snapshot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            delta_q <= 0.0;
            for (int i = 0; i <= N_IN; i++) begin
                w_q[i] <= 0.0;
`ifdef DELTA_DIST_GRAD_EN
                act_q[i] <= 0.0;
`endif
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            delta_q <= delta_d;
            w_q     <= w_d;
`ifdef DELTA_DIST_GRAD_EN
            act_q   <= act_d;
`endif
        end
    end

    // Output decode: handshake flags from state, lane product from the snapshot.
    always_comb begin
        d_ready = 1'b0;
        e_valid = 1'b0;
        busy    = 1'b0;
        e_last  = 1'b0;
        e_index = idx_q;
        e_err   = 0.0;
`ifdef DELTA_DIST_GRAD_EN
        e_grad  = 0.0;
`endif
        if (state_q == STREAM) begin
            e_valid = 1'b1;
            busy    = 1'b1;
            e_last  = (idx_q == LAST_IDX);
            e_err   = delta_q * w_q[idx_q];
`ifdef DELTA_DIST_GRAD_EN
            e_grad  = delta_q * act_q[idx_q];
`endif
        end else begin
            d_ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_delta_distributor.sv
// Self-checking bench for delta_distributor: directed scenarios plus random
// streams, checked against an expected-product model built at each accept.
module tb_delta_distributor;

    localparam int N     = 32;
    localparam int IDX_W = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             d_valid;
    logic             d_ready;
    real              d_delta;
    real              d_weights [N:0];
    logic             e_valid;
    logic             e_ready;
    logic [IDX_W-1:0] e_index;
    real              e_err;
    logic             e_last;
    logic             busy;
`ifdef DELTA_DIST_GRAD_EN
    real              d_acts [N-1:0];
    real              e_grad;
    real              ta [N-1:0];
    real              exp_a [N-1:0];
`endif

    // Stimulus staging and reference snapshot.
    real tw [N:0];
    real exp_w [N:0];
    real exp_d;

    int n_cmp = 0;
    int n_err = 0;

    delta_distributor #(.N_IN(N), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_delta   (d_delta),
        .d_weights (d_weights),
`ifdef DELTA_DIST_GRAD_EN
        .d_acts    (d_acts),
        .e_grad    (e_grad),
`endif
        .e_valid   (e_valid),
        .e_ready   (e_ready),
        .e_index   (e_index),
        .e_err     (e_err),
        .e_last    (e_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_l(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real expv);
        n_cmp++;
        assert (obs == expv) else begin
            n_err++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_l({tag, "_d_ready"}, 32'(d_ready), 32'd1);
        chk_l({tag, "_e_valid"}, 32'(e_valid), 32'd0);
        chk_l({tag, "_e_last"},  32'(e_last),  32'd0);
        chk_l({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    // Present a delta with the staged weights and record the reference snapshot.
    task automatic accept(input real dl, input bit keep_valid);
        d_delta = dl;
        for (int i = 0; i <= N; i++) d_weights[i] = tw[i];
`ifdef DELTA_DIST_GRAD_EN
        for (int i = 0; i < N; i++) begin
            d_acts[i] = ta[i];
            exp_a[i]  = ta[i];
        end
`endif
        d_valid = 1'b1;
        chk_l("accept_d_ready", 32'(d_ready), 32'd1);
        exp_d = dl;
        for (int i = 0; i <= N; i++) exp_w[i] = tw[i];
        @(posedge clk); #1;
        if (!keep_valid) d_valid = 1'b0;
    endtask

    // Walk a stream lane by lane; rmode 0=ready high, 1=pattern 1,0,0,1, 2=random.
    task automatic run_stream(input int rmode, input int mut_lane, input int abort_lane);
        int  lane;
        int  cycles;
        int  k;
        bit  rdy;
        real exp_err;
        lane   = 0;
        cycles = 0;
        k      = 0;
        while (lane <= N) begin
            if (cycles > 300) begin
                chk_l("stream_timeout", 32'(lane), 32'(N + 1));
                break;
            end
            exp_err = exp_d * exp_w[lane];
            chk_l("s_e_valid", 32'(e_valid), 32'd1);
            chk_l("s_d_ready", 32'(d_ready), 32'd0);
            chk_l("s_busy",    32'(busy),    32'd1);
            chk_l("s_e_index", 32'(e_index), 32'(lane));
            chk_l("s_e_last",  32'(e_last),  32'(lane == N));
            chk_r("s_e_err",   e_err,        exp_err);
`ifdef DELTA_DIST_GRAD_EN
            chk_r("s_e_grad", e_grad, (lane < N) ? exp_d * exp_a[lane] : exp_d);
`endif
            if (lane == abort_lane) begin
                rst_n   = 1'b0;
                d_valid = 1'b1;
                @(posedge clk); #1;
                chk_idle("abort");
                chk_l("abort_e_index", 32'(e_index), 32'd0);
                chk_r("abort_e_err", e_err, 0.0);
                rst_n   = 1'b1;
                d_valid = 1'b0;
                @(posedge clk); #1;
                chk_idle("abort_after");
                return;
            end
            if (lane == mut_lane) begin
                d_delta = -1.0;
                for (int i = 0; i <= N; i++) d_weights[i] = 9.0;
`ifdef DELTA_DIST_GRAD_EN
                for (int i = 0; i < N; i++) d_acts[i] = 9.0;
`endif
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            k++;
            e_ready = rdy;
            @(posedge clk); #1;
            cycles++;
            if (rdy) lane++;
        end
        e_ready = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        d_valid = 1'b1;
        d_delta = 5.0;
        e_ready = 1'b1;
        for (int i = 0; i <= N; i++) begin
            d_weights[i] = 1.0;
            tw[i]        = real'(i) * 0.5;
        end
`ifdef DELTA_DIST_GRAD_EN
        for (int i = 0; i < N; i++) begin
            d_acts[i] = 1.0;
            ta[i]     = real'(i);
        end
`endif
        // Reset, with d_valid asserted: reset must win.
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk_l("reset_e_index", 32'(e_index), 32'd0);
        chk_r("reset_e_err", e_err, 0.0);
`ifdef DELTA_DIST_GRAD_EN
        chk_r("reset_e_grad", e_grad, 0.0);
`endif
        rst_n   = 1'b1;
        d_valid = 1'b0;
        @(posedge clk); #1;
        chk_idle("post_reset");

        // Basic stream with ready high; delta 2.0 (grad build uses 0.5).
`ifdef DELTA_DIST_GRAD_EN
        accept(0.5, 1'b0);
`else
        accept(2.0, 1'b0);
`endif
        run_stream(0, -1, -1);
        chk_idle("basic_end");

        // Backpressure pattern 1,0,0,1.
        accept(2.0, 1'b0);
        run_stream(1, -1, -1);
        chk_idle("stall_end");

        // Inputs changed mid-stream must not affect the snapshot.
        accept(2.0, 1'b0);
        run_stream(1, 3, -1);
        chk_idle("snap_end");

        // Reset while lane 10 is presented, then a fresh delta.
        accept(2.0, 1'b0);
        run_stream(0, -1, 10);
        tw[0] = 1.0;
        accept(-3.0, 1'b0);
        chk_r("after_abort_lane0", e_err, -3.0);
        run_stream(0, -1, -1);
        chk_idle("after_abort_end");

        // Back-to-back with d_valid held: second accept one cycle after e_last.
        for (int i = 0; i <= N; i++) tw[i] = real'(i) - 7.0;
        accept(1.0, 1'b1);
        d_delta = 4.0;
        for (int i = 0; i <= N; i++) d_weights[i] = real'(i) * 0.25;
        run_stream(0, -1, -1);
        chk_idle("b2b_gap");
        exp_d = 4.0;
        for (int i = 0; i <= N; i++) exp_w[i] = real'(i) * 0.25;
        @(posedge clk); #1;
        d_valid = 1'b0;
        run_stream(0, -1, -1);
        chk_idle("b2b_end");

        // Random streams with signed values, zeros and infinities.
        for (int s = 0; s < 3; s++) begin
            real dl;
            for (int i = 0; i <= N; i++)
                tw[i] = real'(int'($urandom_range(0, 2000)) - 1000) / 8.0;
            tw[3] = $bitstoreal(64'h7FF0_0000_0000_0000);
            tw[4] = $bitstoreal(64'hFFF0_0000_0000_0000);
            tw[7] = 0.0;
`ifdef DELTA_DIST_GRAD_EN
            for (int i = 0; i < N; i++)
                ta[i] = real'(int'($urandom_range(0, 200)) - 100) / 4.0;
`endif
            dl = real'(int'($urandom_range(1, 400)) - 200) / 16.0;
            if (dl == 0.0) dl = 1.5;
            accept(dl, 1'b0);
            run_stream(2, -1, -1);
            chk_idle("rand_end");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
